// File: rtl/scoreboard_register_file_if.sv
// Bus bundle for scoreboard_register_file: write ports, issue port, reads and status.
interface scoreboard_register_file_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned NRD   = 2
);
  localparam int unsigned IDXW = $clog2(NREGS);

  logic                 we0;
  logic [IDXW-1:0]      waddr0;
  logic [XLEN-1:0]      wdata0;
  logic                 we1;
  logic [IDXW-1:0]      waddr1;
  logic [XLEN-1:0]      wdata1;
  logic [NRD*IDXW-1:0]  raddr;
  logic [NRD*XLEN-1:0]  rdata;
  logic [NRD-1:0]       rbusy;
  logic                 issue_en;
  logic [IDXW-1:0]      issue_idx;
  logic [NREGS-1:0]     busy_vec;
  logic [IDXW:0]        busy_count;
  logic [XLEN-1:0]      debug_out;

  modport master (
    output we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, issue_en, issue_idx,
    input  rdata, rbusy, busy_vec, busy_count, debug_out
  );

  modport slave (
    input  we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, issue_en, issue_idx,
    output rdata, rbusy, busy_vec, busy_count, debug_out
  );
endinterface

// File: rtl/scoreboard_register_file.sv
// Register file with two write ports, NRD combinational read ports and a per-register
// pending (scoreboard) bit set by issue and cleared by a committed write.
module scoreboard_register_file #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NREGS     = 32,
  parameter int unsigned NRD       = 2,
  parameter bit          ZERO_REG  = 1'b1,
  parameter bit          BYPASS    = 1'b1,
  parameter int unsigned DEBUG_IDX = 10
) (
  input logic                       clk,
  input logic                       reset,
  scoreboard_register_file_if.slave bus
);
  localparam int unsigned IDXW = $clog2(NREGS);
  localparam logic [IDXW-1:0] DBG_ADDR = IDXW'(DEBUG_IDX);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [IDXW:0]    count_q, count_d;
  logic             we0_eff, we1_eff, issue_eff;

  // Register 0 swallows writes and issues when it is hardwired to zero
  assign we0_eff   = bus.we0 && !(ZERO_REG && (bus.waddr0 == '0));
  assign we1_eff   = bus.we1 && !(ZERO_REG && (bus.waddr1 == '0));
  assign issue_eff = bus.issue_en && !(ZERO_REG && (bus.issue_idx == '0));

  // Pending bits: writes clear, issue sets afterwards so a new producer wins
  always_comb begin
    busy_d = busy_q;
    if (we0_eff) busy_d[bus.waddr0] = 1'b0;
    if (we1_eff) busy_d[bus.waddr1] = 1'b0;
    if (issue_eff) busy_d[bus.issue_idx] = 1'b1;
    count_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      count_d = count_d + (IDXW+1)'(busy_d[i]);
    end
  end

  // Commit writes (port 1 assigned last so it wins a collision) and scoreboard state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      if (we0_eff) regs_q[bus.waddr0] <= bus.wdata0;
      if (we1_eff) regs_q[bus.waddr1] <= bus.wdata1;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [IDXW-1:0] addr;
    logic [XLEN-1:0] data;
    logic            busy;
    logic            hit0, hit1, issued;

    assign addr   = bus.raddr[k*IDXW +: IDXW];
    assign hit0   = we0_eff && (bus.waddr0 == addr);
    assign hit1   = we1_eff && (bus.waddr1 == addr);
    assign issued = issue_eff && (bus.issue_idx == addr);

    // Read mux: forward the winning write; a completing producer is no longer busy
    always_comb begin
      data = regs_q[addr];
      busy = busy_q[addr];
      if (BYPASS) begin
        if (hit1) begin
          data = bus.wdata1;
        end else if (hit0) begin
          data = bus.wdata0;
        end
        if ((hit0 || hit1) && !issued) busy = 1'b0;
      end
      // Reset hides in-flight writes; the zero register overrides forwarding
      if (reset || (ZERO_REG && (addr == '0))) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign bus.rdata[k*XLEN +: XLEN] = data;
    assign bus.rbusy[k]              = busy;
  end

  assign bus.busy_vec   = busy_q;
  assign bus.busy_count = count_q;
  assign bus.debug_out  = regs_q[DBG_ADDR];
endmodule

// File: tb/tb_scoreboard_register_file.sv
// Self-checking bench: directed vector table, reset sequences, then random traffic
// against a behavioural model of the register file and scoreboard.
module tb_scoreboard_register_file;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 16;
  localparam int unsigned NRD   = 3;
  localparam int unsigned IDXW  = 4;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  scoreboard_register_file_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();
  scoreboard_register_file_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus_nb ();

  scoreboard_register_file #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1'b1), .BYPASS(1'b1), .DEBUG_IDX(10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  scoreboard_register_file #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1'b1), .BYPASS(1'b0), .DEBUG_IDX(10)
  ) dut_nb (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_nb)
  );

  // Second instance sees identical stimulus
  assign bus_nb.we0       = bus.we0;
  assign bus_nb.waddr0    = bus.waddr0;
  assign bus_nb.wdata0    = bus.wdata0;
  assign bus_nb.we1       = bus.we1;
  assign bus_nb.waddr1    = bus.waddr1;
  assign bus_nb.wdata1    = bus.wdata1;
  assign bus_nb.raddr     = bus.raddr;
  assign bus_nb.issue_en  = bus.issue_en;
  assign bus_nb.issue_idx = bus.issue_idx;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            we0;
    logic [IDXW-1:0] wa0;
    logic [31:0]     wd0;
    logic            we1;
    logic [IDXW-1:0] wa1;
    logic [31:0]     wd1;
    logic            iss;
    logic [IDXW-1:0] ii;
    logic [IDXW-1:0] ra;
    logic [31:0]     rd;
    logic [31:0]     rd_nb;
    logic            rb;
    logic [IDXW:0]   cnt;
  } vec_t;

  vec_t tbl [17];

  // Behavioural model state
  logic [31:0] mregs [NREGS];
  bit          mbusy [NREGS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle();
    bus.we0 = 0; bus.waddr0 = 0; bus.wdata0 = 0;
    bus.we1 = 0; bus.waddr1 = 0; bus.wdata1 = 0;
    bus.issue_en = 0; bus.issue_idx = 0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREGS; i++) begin
      mregs[i] = 0;
      mbusy[i] = 0;
    end
  endtask

  function automatic logic [31:0] exp_rdata(input logic [IDXW-1:0] a);
    if (a == 0) return 0;
    if (bus.we1 && bus.waddr1 == a) return bus.wdata1;
    if (bus.we0 && bus.waddr0 == a) return bus.wdata0;
    return mregs[a];
  endfunction

  function automatic logic exp_rbusy(input logic [IDXW-1:0] a);
    bit written;
    bit issued;
    if (a == 0) return 0;
    written = (bus.we0 && bus.waddr0 == a) || (bus.we1 && bus.waddr1 == a);
    issued  = bus.issue_en && bus.issue_idx == a;
    return mbusy[a] && !(written && !issued);
  endfunction

  task automatic model_edge();
    if (bus.we0 && bus.waddr0 != 0) begin
      mregs[bus.waddr0] = bus.wdata0;
      mbusy[bus.waddr0] = 0;
    end
    if (bus.we1 && bus.waddr1 != 0) begin
      mregs[bus.waddr1] = bus.wdata1;
      mbusy[bus.waddr1] = 0;
    end
    if (bus.issue_en && bus.issue_idx != 0) mbusy[bus.issue_idx] = 1;
  endtask

  function automatic logic [NREGS-1:0] model_vec();
    logic [NREGS-1:0] v;
    for (int i = 0; i < NREGS; i++) v[i] = mbusy[i];
    return v;
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < NREGS; i++) c += int'(mbusy[i]);
    return c;
  endfunction

  initial begin
    logic [IDXW-1:0] ra [NRD];
    n_pass  = 0;
    n_total = 0;
    //             we0 wa0 wd0           we1 wa1 wd1           iss ii  ra  rd            rd_nb         rb cnt
    tbl[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0,            0, 0, 5, 32'hDEADBEEF, 32'h0,        0, 0};
    tbl[1]  = '{0, 0, 0,            0, 0, 0,            0, 0, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0};
    tbl[2]  = '{1, 7, 32'h11,       1, 7, 32'h22,       0, 0, 7, 32'h22,       32'h0,        0, 0};
    tbl[3]  = '{0, 0, 0,            0, 0, 0,            0, 0, 7, 32'h22,       32'h22,       0, 0};
    tbl[4]  = '{0, 0, 0,            1, 0, 32'hFFFFFFFF, 1, 0, 0, 32'h0,        32'h0,        0, 0};
    tbl[5]  = '{1, 0, 32'hFFFFFFFF, 0, 0, 0,            0, 0, 0, 32'h0,        32'h0,        0, 0};
    tbl[6]  = '{0, 0, 0,            0, 0, 0,            1, 3, 3, 32'h0,        32'h0,        0, 1};
    tbl[7]  = '{0, 0, 0,            0, 0, 0,            1, 4, 3, 32'h0,        32'h0,        1, 2};
    tbl[8]  = '{0, 0, 0,            0, 0, 0,            1, 5, 4, 32'h0,        32'h0,        1, 3};
    tbl[9]  = '{1, 4, 32'hAAAA,     0, 0, 0,            0, 0, 4, 32'hAAAA,     32'h0,        0, 2};
    tbl[10] = '{0, 0, 0,            0, 0, 0,            0, 0, 4, 32'hAAAA,     32'hAAAA,     0, 2};
    tbl[11] = '{0, 0, 0,            1, 9, 32'h99,       1, 9, 9, 32'h99,       32'h0,        0, 3};
    tbl[12] = '{0, 0, 0,            0, 0, 0,            0, 0, 9, 32'h99,       32'h99,       1, 3};
    tbl[13] = '{0, 0, 0,            0, 0, 0,            1, 9, 9, 32'h99,       32'h99,       1, 3};
    tbl[14] = '{1, 9, 32'h77,       0, 0, 0,            1, 9, 9, 32'h77,       32'h99,       1, 3};
    tbl[15] = '{1, 3, 32'h1,        1, 5, 32'h2,        0, 0, 3, 32'h1,        32'h0,        0, 1};
    tbl[16] = '{1, 10, 32'h1234,    0, 0, 0,            0, 0, 10, 32'h1234,    32'h0,        0, 1};

    // Reset state
    reset = 1'b1;
    idle();
    bus.raddr = '0;
    #2;
    check("reset_count", 64'(bus.busy_count), 0);
    check("reset_vec", 64'(bus.busy_vec), 0);
    check("reset_debug", 64'(bus.debug_out), 0);
    @(negedge clk);
    reset = 1'b0;

    // Directed vectors
    for (int i = 0; i < 17; i++) begin
      bus.we0 = tbl[i].we0; bus.waddr0 = tbl[i].wa0; bus.wdata0 = tbl[i].wd0;
      bus.we1 = tbl[i].we1; bus.waddr1 = tbl[i].wa1; bus.wdata1 = tbl[i].wd1;
      bus.issue_en = tbl[i].iss; bus.issue_idx = tbl[i].ii;
      bus.raddr = {4'd0, 4'd0, tbl[i].ra};
      #1;
      check($sformatf("vec%0d_rdata", i), 64'(bus.rdata[31:0]), 64'(tbl[i].rd));
      check($sformatf("vec%0d_rdata_nobypass", i), 64'(bus_nb.rdata[31:0]), 64'(tbl[i].rd_nb));
      check($sformatf("vec%0d_rbusy", i), 64'(bus.rbusy[0]), 64'(tbl[i].rb));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_count", i), 64'(bus.busy_count), 64'(tbl[i].cnt));
      @(negedge clk);
    end

    // Zero register never pending; debug mirrors reg 10
    idle();
    bus.raddr = {4'd0, 4'd0, 4'd10};
    #1;
    check("zero_not_busy", 64'(bus.busy_vec[0]), 0);
    check("busy_vec_after_table", 64'(bus.busy_vec), 64'(16'h0200));
    check("debug_reg10", 64'(bus.debug_out), 64'h1234);

    // Asynchronous reset between edges clears everything before the next edge
    #1;
    reset = 1'b1;
    #1;
    check("async_debug", 64'(bus.debug_out), 0);
    check("async_vec", 64'(bus.busy_vec), 0);
    check("async_count", 64'(bus.busy_count), 0);
    check("async_rdata", 64'(bus.rdata[31:0]), 0);

    // Writes and issues presented during reset are discarded and not forwarded
    bus.we0 = 1; bus.waddr0 = 6; bus.wdata0 = 32'h55;
    bus.issue_en = 1; bus.issue_idx = 6;
    bus.raddr = {4'd0, 4'd0, 4'd6};
    #1;
    check("reset_no_bypass", 64'(bus.rdata[31:0]), 0);
    check("reset_rbusy", 64'(bus.rbusy), 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle();
    #1;
    check("reset_write_dropped", 64'(bus.rdata[31:0]), 0);
    @(posedge clk);
    #1;
    check("reset_issue_dropped", 64'(bus.busy_count), 0);
    @(negedge clk);

    // Random traffic against the model
    model_clear();
    for (int c = 0; c < 400; c++) begin
      bus.we0 = 1'($urandom_range(0, 1));
      bus.waddr0 = IDXW'($urandom_range(0, NREGS-1));
      bus.wdata0 = $urandom;
      bus.we1 = 1'($urandom_range(0, 1));
      bus.waddr1 = ($urandom_range(0, 3) == 0) ? bus.waddr0 : IDXW'($urandom_range(0, NREGS-1));
      bus.wdata1 = $urandom;
      bus.issue_en = 1'($urandom_range(0, 1));
      bus.issue_idx = ($urandom_range(0, 3) == 0) ? bus.waddr1 : IDXW'($urandom_range(0, NREGS-1));
      for (int k = 0; k < NRD; k++) begin
        case ($urandom_range(0, 3))
          0: ra[k] = bus.waddr0;
          1: ra[k] = bus.waddr1;
          2: ra[k] = bus.issue_idx;
          default: ra[k] = IDXW'($urandom_range(0, NREGS-1));
        endcase
      end
      bus.raddr = {ra[2], ra[1], ra[0]};
      #1;
      for (int k = 0; k < NRD; k++) begin
        check($sformatf("rnd%0d_rdata%0d", c, k), 64'(bus.rdata[k*XLEN +: XLEN]),
              64'(exp_rdata(ra[k])));
        check($sformatf("rnd%0d_rbusy%0d", c, k), 64'(bus.rbusy[k]), 64'(exp_rbusy(ra[k])));
      end
      check($sformatf("rnd%0d_debug", c), 64'(bus.debug_out), 64'(mregs[10]));
      @(posedge clk);
      model_edge();
      #1;
      check($sformatf("rnd%0d_count", c), 64'(bus.busy_count), 64'(model_count()));
      check($sformatf("rnd%0d_vec", c), 64'(bus.busy_vec), 64'(model_vec()));
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/scoreboard_register_file.md
SCOREBOARD_REGISTER_FILE -- requirements
Module: scoreboard_register_file

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have parameter NREGS, default 32, register count (power of two, >=2); IDXW = $clog2(NREGS) derived.
REQ-003 SHALL have parameter NRD, default 2, number of read ports.
REQ-004 SHALL have parameter ZERO_REG, default 1, register 0 hardwired to zero when 1.
REQ-005 SHALL have parameter BYPASS, default 1, write-to-read forwarding enabled when 1.
REQ-006 SHALL have parameter DEBUG_IDX, default 10, register mirrored on debug_out.
REQ-007 clk  input  1  sole clock, rising-edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 we0 / waddr0 / wdata0  input  1 / IDXW / XLEN  write port 0.
REQ-010 we1 / waddr1 / wdata1  input  1 / IDXW / XLEN  write port 1, higher priority.
REQ-011 raddr  input  NRD*IDXW  packed read addresses, port k at bits [k*IDXW +: IDXW].
REQ-012 rdata  output  NRD*XLEN  packed read data, same packing.
REQ-013 rbusy  output  NRD  per-port: addressed register has a pending producer.
REQ-014 issue_en / issue_idx  input  1 / IDXW  mark register pending (new producer issued).
REQ-015 busy_vec  output  NREGS  pending bit per register.
REQ-016 busy_count  output  IDXW+1  number of set pending bits.
REQ-017 debug_out  output  XLEN  current content of register DEBUG_IDX.

Function
REQ-018 Writes SHALL commit at rising clk; we1 and we0 to the same address SHALL store wdata1 only.
REQ-019 With ZERO_REG=1, register 0 SHALL read 0, ignore writes, never become pending.
REQ-020 Reads SHALL be combinational; with BYPASS=1, a read of an address being written this cycle SHALL return the winning write data (port 1 over port 0); with BYPASS=0 it SHALL return the stored value.
REQ-021 Zero-register rule SHALL override bypass.
REQ-022 issue_en SHALL set busy_vec[issue_idx] at the next edge.
REQ-023 A committed write (either port) SHALL clear that register's pending bit at the next edge.
REQ-024 Issue and write to the same register in one cycle SHALL leave the bit set (new producer wins).
REQ-025 Writes to a non-pending register SHALL update data and leave the bit clear; issue to an already-pending register SHALL keep it set.
REQ-026 rbusy[k] SHALL equal busy_vec[raddr_k], except with BYPASS=1 it SHALL be 0 when that register is written this cycle and not simultaneously issued.
REQ-027 busy_count SHALL be registered, equal to popcount(busy_vec) in the same cycle, range 0..NREGS (NREGS-1 when ZERO_REG=1).
REQ-028 debug_out SHALL show stored (not bypassed) value; 0 when ZERO_REG=1 and DEBUG_IDX=0.

Reset
REQ-029 reset high SHALL immediately clear all registers, busy_vec, busy_count; rdata reads 0, rbusy 0, debug_out 0.
REQ-030 Writes and issues presented while reset is high SHALL be discarded; first commit on first rising edge after reset deasserts.
REQ-031 Reset asserted mid-operation SHALL discard all pending state with no partial writes.

Verification
REQ-032 we0=1,waddr0=5,wdata0=0xDEADBEEF, raddr0=5 same cycle -> rdata0=0xDEADBEEF (BYPASS=1) / 0 (BYPASS=0); next cycle both 0xDEADBEEF.
REQ-033 we0 and we1 both to reg 7 with 0x11, 0x22 -> reg 7 = 0x22; write reg 0 = 0xFFFFFFFF -> reads 0, busy_vec[0]=0.
REQ-034 issue regs 3,4,5 over three cycles -> busy_count 1,2,3; write reg 4 -> busy_vec[4]=0, busy_count=2; rbusy on raddr=4 drops in write cycle with BYPASS=1.
REQ-035 issue_idx=9 and we1 waddr1=9 same cycle -> reg 9 updated, busy_vec[9] stays 1.
REQ-036 write reg 10 = 0x1234, then assert reset asynchronously between edges -> debug_out, busy_vec, busy_count 0 before next edge.
REQ-037 Randomised issue/write sequence against reference model, NREGS=16, NRD=3 -> rdata, rbusy, busy_count match every cycle.
